// File: rtl/sm_chk_pkg.sv
// Shared types and edge-table constants for the stimulus state machine checker.
// The stimulus machine has 11 legal state codes (0..10) and 18 legal edges.
package sm_chk_pkg;

  localparam int NUM_STATES = 11;
  localparam int NUM_EDGES  = 18;

  typedef enum logic [3:0] {
    ST_0  = 4'd0,
    ST_1  = 4'd1,
    ST_2  = 4'd2,
    ST_3  = 4'd3,
    ST_4  = 4'd4,
    ST_5  = 4'd5,
    ST_6  = 4'd6,
    ST_7  = 4'd7,
    ST_8  = 4'd8,
    ST_9  = 4'd9,
    ST_10 = 4'd10
  } state_e;

  localparam logic [3:0] MAX_STATE = 4'(NUM_STATES - 1);

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_RANGE    = 2'd1,
    ERR_MISMATCH = 2'd2,
    ERR_EDGE     = 2'd3
  } err_code_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    CHECK = 2'd2,
    HALT  = 2'd3
  } fsm_e;

  // Edge coverage bit positions, named from->to.
  localparam logic [4:0] E_0_1  = 5'd0;
  localparam logic [4:0] E_1_2  = 5'd1;
  localparam logic [4:0] E_1_4  = 5'd2;
  localparam logic [4:0] E_2_3  = 5'd3;
  localparam logic [4:0] E_3_1  = 5'd4;
  localparam logic [4:0] E_3_5  = 5'd5;
  localparam logic [4:0] E_4_5  = 5'd6;
  localparam logic [4:0] E_5_1  = 5'd7;
  localparam logic [4:0] E_5_6  = 5'd8;
  localparam logic [4:0] E_6_7  = 5'd9;
  localparam logic [4:0] E_7_0  = 5'd10;
  localparam logic [4:0] E_7_8  = 5'd11;
  localparam logic [4:0] E_8_2  = 5'd12;
  localparam logic [4:0] E_8_4  = 5'd13;
  localparam logic [4:0] E_8_9  = 5'd14;
  localparam logic [4:0] E_8_10 = 5'd15;
  localparam logic [4:0] E_9_0  = 5'd16;
  localparam logic [4:0] E_10_0 = 5'd17;

  // A stimulus machine that wandered out of range is allowed to land back on 4.
  function automatic logic is_recovery(logic [3:0] from_state, logic [3:0] to_state);
    return (from_state > MAX_STATE) && (to_state == ST_4);
  endfunction

endpackage

// File: rtl/sm_transition_checker_if.sv
// Bus between the stimulus side (master) and the transition checker (slave).
// CNT_W must match the checker instance attached to the slave modport.
interface sm_transition_checker_if
  import sm_chk_pkg::*;
#(
  parameter int CNT_W = 16
);

  logic                  en;
  logic                  clr;
  logic [3:0]            state;
  logic [3:0]            old_state;

  logic                  err_pulse;
  logic [1:0]            err_code;
  logic                  sticky_err;
  logic [3:0]            first_from;
  logic [3:0]            first_to;
  logic [CNT_W-1:0]      err_count;
  logic [CNT_W-1:0]      trans_count;
  logic [NUM_STATES-1:0] state_cov;
  logic [NUM_EDGES-1:0]  edge_cov;
  logic                  cov_done;

  modport master (
    output en, clr, state, old_state,
    input  err_pulse, err_code, sticky_err, first_from, first_to,
           err_count, trans_count, state_cov, edge_cov, cov_done
  );

  modport slave (
    input  en, clr, state, old_state,
    output err_pulse, err_code, sticky_err, first_from, first_to,
           err_count, trans_count, state_cov, edge_cov, cov_done
  );

endinterface

// File: rtl/sm_edge_decoder.sv
// Combinational lookup of a (from, to) state pair in the legal edge table.
// idx is only meaningful while legal is high; recover flags the out-of-range -> 4 escape.
module sm_edge_decoder
  import sm_chk_pkg::*;
(
  input  logic [3:0] from_state,
  input  logic [3:0] to_state,
  output logic       legal,
  output logic       recover,
  output logic [4:0] idx
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path can infer a latch.
    legal   = 1'b1;
    idx     = '0;
    recover = is_recovery(from_state, to_state);
    case ({from_state, to_state})
      {ST_0,  ST_1 }: idx = E_0_1;
      {ST_1,  ST_2 }: idx = E_1_2;
      {ST_1,  ST_4 }: idx = E_1_4;
      {ST_2,  ST_3 }: idx = E_2_3;
      {ST_3,  ST_1 }: idx = E_3_1;
      {ST_3,  ST_5 }: idx = E_3_5;
      {ST_4,  ST_5 }: idx = E_4_5;
      {ST_5,  ST_1 }: idx = E_5_1;
      {ST_5,  ST_6 }: idx = E_5_6;
      {ST_6,  ST_7 }: idx = E_6_7;
      {ST_7,  ST_0 }: idx = E_7_0;
      {ST_7,  ST_8 }: idx = E_7_8;
      {ST_8,  ST_2 }: idx = E_8_2;
      {ST_8,  ST_4 }: idx = E_8_4;
      {ST_8,  ST_9 }: idx = E_8_9;
      {ST_8,  ST_10}: idx = E_8_10;
      {ST_9,  ST_0 }: idx = E_9_0;
      {ST_10, ST_0 }: idx = E_10_0;
      default:        legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/sm_transition_checker.sv
// Receiver/checker for the 11-state stimulus machine: flags range, old_state and edge errors,
// counts transitions and errors (saturating), and records state/edge coverage.
module sm_transition_checker
  import sm_chk_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter bit STOP_ON_ERR = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst,
  sm_transition_checker_if.slave bus
);

  fsm_e                  fsm_q;
  logic [3:0]            prev_q;
  logic                  err_pulse_q;
  err_code_e             err_code_q;
  logic                  sticky_q;
  logic [3:0]            first_from_q;
  logic [3:0]            first_to_q;
  logic [CNT_W-1:0]      err_count_q;
  logic [CNT_W-1:0]      trans_count_q;
  logic [NUM_STATES-1:0] state_cov_q;
  logic [NUM_EDGES-1:0]  edge_cov_q;

  logic       edge_legal;
  logic       edge_recover;
  logic [4:0] edge_idx;
  logic       range_err;
  logic       mismatch_err;
  logic       edge_err;
  err_code_e  code_now;

  sm_edge_decoder u_edge_decoder (
    .from_state (prev_q),
    .to_state   (bus.state),
    .legal      (edge_legal),
    .recover    (edge_recover),
    .idx        (edge_idx)
  );

  // One code per cycle: range beats mismatch beats edge.
  always_comb begin
    range_err    = bus.state > MAX_STATE;
    mismatch_err = bus.old_state != prev_q;
    edge_err     = !(edge_legal || edge_recover);
    code_now     = ERR_NONE;
    if (range_err)         code_now = ERR_RANGE;
    else if (mismatch_err) code_now = ERR_MISMATCH;
    else if (edge_err)     code_now = ERR_EDGE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q         <= IDLE;
      prev_q        <= '0;
      err_pulse_q   <= 1'b0;
      err_code_q    <= ERR_NONE;
      sticky_q      <= 1'b0;
      first_from_q  <= '0;
      first_to_q    <= '0;
      err_count_q   <= '0;
      trans_count_q <= '0;
      state_cov_q   <= '0;
      edge_cov_q    <= '0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every read below sees
      // the value from before this edge, regardless of statement order.
      err_pulse_q <= 1'b0;
      err_code_q  <= ERR_NONE;

      if (bus.clr) begin
        // Clear wins over enable and over any error seen in the same cycle.
        fsm_q         <= PRIME;
        sticky_q      <= 1'b0;
        first_from_q  <= '0;
        first_to_q    <= '0;
        err_count_q   <= '0;
        trans_count_q <= '0;
        state_cov_q   <= '0;
        edge_cov_q    <= '0;
      end else if (!bus.en) begin
        fsm_q <= IDLE;
      end else begin
        unique case (fsm_q)
          IDLE: fsm_q <= PRIME;

          PRIME: begin
            prev_q <= bus.state;
            fsm_q  <= CHECK;
          end

          CHECK: begin
            prev_q <= bus.state;
            if (trans_count_q != '1) trans_count_q <= trans_count_q + 1'b1;
            if (!range_err)          state_cov_q[bus.state] <= 1'b1;
            if (edge_legal)          edge_cov_q[edge_idx]   <= 1'b1;

            if (code_now != ERR_NONE) begin
              err_pulse_q <= 1'b1;
              err_code_q  <= code_now;
              if (err_count_q != '1) err_count_q <= err_count_q + 1'b1;
              if (!sticky_q) begin
                sticky_q     <= 1'b1;
                first_from_q <= prev_q;
                first_to_q   <= bus.state;
              end
              if (STOP_ON_ERR) fsm_q <= HALT;
            end
          end

          HALT: fsm_q <= HALT;

          default: fsm_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.err_pulse   = err_pulse_q;
  assign bus.err_code    = err_code_q;
  assign bus.sticky_err  = sticky_q;
  assign bus.first_from  = first_from_q;
  assign bus.first_to    = first_to_q;
  assign bus.err_count   = err_count_q;
  assign bus.trans_count = trans_count_q;
  assign bus.state_cov   = state_cov_q;
  assign bus.edge_cov    = edge_cov_q;
  assign bus.cov_done    = &edge_cov_q;

endmodule

// File: tb/tb_sm_transition_checker.sv
// Bench for sm_transition_checker: three instances (free-running, stop-on-error, 4-bit counters)
// share one stimulus stream and are compared every cycle against a table-driven reference model.
module tb_sm_transition_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic       clr = 1'b0;
  logic [3:0] st  = 4'd0;
  logic [3:0] old = 4'd0;

  always #5 clk = ~clk;

  sm_transition_checker_if #(.CNT_W(16)) if_a ();
  sm_transition_checker_if #(.CNT_W(16)) if_b ();
  sm_transition_checker_if #(.CNT_W(4))  if_c ();

  assign if_a.en = en;  assign if_a.clr = clr;  assign if_a.state = st;  assign if_a.old_state = old;
  assign if_b.en = en;  assign if_b.clr = clr;  assign if_b.state = st;  assign if_b.old_state = old;
  assign if_c.en = en;  assign if_c.clr = clr;  assign if_c.state = st;  assign if_c.old_state = old;

  sm_transition_checker #(.CNT_W(16), .STOP_ON_ERR(1'b0)) dut_a (.clk(clk), .rst(rst), .bus(if_a.slave));
  sm_transition_checker #(.CNT_W(16), .STOP_ON_ERR(1'b1)) dut_b (.clk(clk), .rst(rst), .bus(if_b.slave));
  sm_transition_checker #(.CNT_W(4),  .STOP_ON_ERR(1'b0)) dut_c (.clk(clk), .rst(rst), .bus(if_c.slave));

  // Observed outputs, widened to a common shape so the three instances can be looped over.
  logic        o_pulse [3];
  logic [1:0]  o_code  [3];
  logic        o_stk   [3];
  logic [3:0]  o_ff    [3];
  logic [3:0]  o_ft    [3];
  logic [15:0] o_ec    [3];
  logic [15:0] o_tc    [3];
  logic [10:0] o_sc    [3];
  logic [17:0] o_ecv   [3];
  logic        o_done  [3];

  assign o_pulse[0] = if_a.err_pulse;  assign o_pulse[1] = if_b.err_pulse;  assign o_pulse[2] = if_c.err_pulse;
  assign o_code[0]  = if_a.err_code;   assign o_code[1]  = if_b.err_code;   assign o_code[2]  = if_c.err_code;
  assign o_stk[0]   = if_a.sticky_err; assign o_stk[1]   = if_b.sticky_err; assign o_stk[2]   = if_c.sticky_err;
  assign o_ff[0]    = if_a.first_from; assign o_ff[1]    = if_b.first_from; assign o_ff[2]    = if_c.first_from;
  assign o_ft[0]    = if_a.first_to;   assign o_ft[1]    = if_b.first_to;   assign o_ft[2]    = if_c.first_to;
  assign o_ec[0]    = if_a.err_count;  assign o_ec[1]    = if_b.err_count;  assign o_ec[2]    = {12'd0, if_c.err_count};
  assign o_tc[0]    = if_a.trans_count; assign o_tc[1]   = if_b.trans_count; assign o_tc[2]   = {12'd0, if_c.trans_count};
  assign o_sc[0]    = if_a.state_cov;  assign o_sc[1]    = if_b.state_cov;  assign o_sc[2]    = if_c.state_cov;
  assign o_ecv[0]   = if_a.edge_cov;   assign o_ecv[1]   = if_b.edge_cov;   assign o_ecv[2]   = if_c.edge_cov;
  assign o_done[0]  = if_a.cov_done;   assign o_done[1]  = if_b.cov_done;   assign o_done[2]  = if_c.cov_done;

  // ---------------- reference model ----------------
  localparam int M_IDLE = 0, M_PRIME = 1, M_CHECK = 2, M_HALT = 3;

  typedef struct {
    int        mode;
    int        prev;
    bit        pulse;
    int        code;
    bit        sticky;
    int        ff;
    int        ft;
    int        ec;
    int        tc;
    bit [10:0] sc;
    bit [17:0] ecv;
  } mdl_t;

  mdl_t  m       [3];
  int    cnt_max [3] = '{65535, 65535, 15};
  bit    stop    [3] = '{1'b0, 1'b1, 1'b0};
  string nm      [3] = '{"a", "b", "c"};

  int edge_from [18] = '{0, 1, 1, 2, 3, 3, 4, 5, 5, 6, 7, 7, 8, 8, 8,  8, 9, 10};
  int edge_to   [18] = '{1, 2, 4, 3, 1, 5, 5, 1, 6, 7, 0, 8, 2, 4, 9, 10, 0, 0};

  localparam int WALK_LEN = 43;
  int walk [WALK_LEN] = '{0, 1, 2, 3, 1, 4, 5, 1, 2, 3, 5, 6, 7, 8, 2, 3, 5, 6, 7, 8,
                          4, 5, 6, 7, 8, 9, 0, 1, 2, 3, 5, 6, 7, 0, 1, 2, 3, 5, 6, 7,
                          8, 10, 0};

  int n_chk  = 0;
  int n_pass = 0;
  int last   = 0;

  function automatic int edge_index(int f, int t);
    for (int k = 0; k < 18; k++)
      if (edge_from[k] == f && edge_to[k] == t) return k;
    return -1;
  endfunction

  function automatic int next_legal(int f);
    int q[$];
    if (f > 10) return 4;
    for (int k = 0; k < 18; k++)
      if (edge_from[k] == f) q.push_back(edge_to[k]);
    return q[$urandom_range(0, q.size() - 1)];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) m[i] = '{default: 0};
  endtask

  task automatic model_step(int i);
    int s, o, e, code;
    s = int'(st);
    o = int'(old);
    if (clr) begin
      m[i].mode = M_PRIME; m[i].pulse = 0; m[i].code = 0; m[i].sticky = 0;
      m[i].ff = 0; m[i].ft = 0; m[i].ec = 0; m[i].tc = 0; m[i].sc = '0; m[i].ecv = '0;
      return;
    end
    m[i].pulse = 0;
    m[i].code  = 0;
    if (!en) begin
      m[i].mode = M_IDLE;
      return;
    end
    case (m[i].mode)
      M_IDLE:  m[i].mode = M_PRIME;
      M_PRIME: begin m[i].prev = s; m[i].mode = M_CHECK; end
      M_CHECK: begin
        e = edge_index(m[i].prev, s);
        if (s > 10)                                  code = 1;
        else if (o != m[i].prev)                     code = 2;
        else if (e < 0 && !(m[i].prev > 10 && s == 4)) code = 3;
        else                                         code = 0;
        if (m[i].tc < cnt_max[i]) m[i].tc++;
        if (s <= 10) m[i].sc[s] = 1'b1;
        if (e >= 0)  m[i].ecv[e] = 1'b1;
        if (code != 0) begin
          m[i].pulse = 1;
          m[i].code  = code;
          if (m[i].ec < cnt_max[i]) m[i].ec++;
          if (!m[i].sticky) begin
            m[i].sticky = 1; m[i].ff = m[i].prev; m[i].ft = s;
          end
          if (stop[i]) m[i].mode = M_HALT;
        end
        m[i].prev = s;
      end
      default: ;
    endcase
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic compare_all();
    for (int i = 0; i < 3; i++) begin
      check({nm[i], ".err_pulse"},   32'(o_pulse[i]), 32'(m[i].pulse));
      check({nm[i], ".err_code"},    32'(o_code[i]),  32'(m[i].code));
      check({nm[i], ".sticky_err"},  32'(o_stk[i]),   32'(m[i].sticky));
      check({nm[i], ".first_from"},  32'(o_ff[i]),    32'(m[i].ff));
      check({nm[i], ".first_to"},    32'(o_ft[i]),    32'(m[i].ft));
      check({nm[i], ".err_count"},   32'(o_ec[i]),    32'(m[i].ec));
      check({nm[i], ".trans_count"}, 32'(o_tc[i]),    32'(m[i].tc));
      check({nm[i], ".state_cov"},   32'(o_sc[i]),    32'(m[i].sc));
      check({nm[i], ".edge_cov"},    32'(o_ecv[i]),   32'(m[i].ecv));
      check({nm[i], ".cov_done"},    32'(o_done[i]),  32'(&m[i].ecv));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) for (int i = 0; i < 3; i++) model_step(i);
    #1;
    compare_all();
  endtask

  task automatic drive(input int s, input int o, input bit e = 1'b1, input bit c = 1'b0);
    st  = 4'(s);
    old = 4'(o);
    en  = e;
    clr = c;
    tick();
    last = s;
  endtask

  // Drive the next state with a correct old_state.
  task automatic go(input int s);
    drive(s, last);
  endtask

  task automatic random_cycles(input int n);
    int r, s, o;
    for (int k = 0; k < n; k++) begin
      r = $urandom_range(0, 99);
      if (r < 70)      s = next_legal(last);
      else if (r < 82) s = $urandom_range(0, 15);
      else             s = last;
      o = ($urandom_range(0, 19) == 0) ? $urandom_range(0, 15) : last;
      drive(s, o, $urandom_range(0, 39) != 0, $urandom_range(0, 59) == 0);
    end
  endtask

  initial begin
    model_reset();
    for (int k = 0; k < 10; k++) tick();

    // Basic legal run: first 0 moves IDLE->PRIME, second 0 primes, then 7 checked transitions.
    @(negedge clk);
    rst = 1'b0;
    drive(0, 0);
    drive(0, 0);
    go(1); go(2); go(3); go(5); go(6); go(7); go(0);
    check("walk.err_count",   32'(o_ec[0]),  32'd0);
    check("walk.trans_count", 32'(o_tc[0]),  32'd7);
    check("walk.edge_cov",    32'(o_ecv[0]), 32'h0072B);
    check("walk.state_cov",   32'(o_sc[0]),  32'h000EF);

    // Illegal 0->2 edge.
    go(2);
    check("edge.err_pulse",  32'(o_pulse[0]), 32'd1);
    check("edge.err_code",   32'(o_code[0]),  32'd3);
    check("edge.first_from", 32'(o_ff[0]),    32'd0);
    check("edge.first_to",   32'(o_ft[0]),    32'd2);
    check("edge.sticky",     32'(o_stk[0]),   32'd1);

    // Out-of-range code, then recovery edge back to 4.
    go(12);
    check("range.err_code",  32'(o_code[0]),  32'd1);
    check("range.first_to",  32'(o_ft[0]),    32'd2);
    go(4);
    check("recover.err_pulse", 32'(o_pulse[0]), 32'd0);
    check("recover.err_count", 32'(o_ec[0]),    32'd2);

    // Legal 3->5 with a wrong old_state reports MISMATCH; prev becomes 5.
    go(5); go(1); go(2); go(3);
    drive(5, 4);
    check("mismatch.err_code", 32'(o_code[0]), 32'd2);
    go(6);
    check("mismatch.next_pulse", 32'(o_pulse[0]), 32'd0);
    check("mismatch.err_count",  32'(o_ec[0]),    32'd3);

    // Stop-on-error instance halted at the 0->2 edge and ignores everything since.
    check("halt.err_count",   32'(o_ec[1]),    32'd1);
    check("halt.trans_count", 32'(o_tc[1]),    32'd8);
    check("halt.err_pulse",   32'(o_pulse[1]), 32'd0);

    // Clear: everything zero, next cycle only primes.
    drive(7, 6, 1'b1, 1'b1);
    check("clr.trans_count", 32'(o_tc[1]),  32'd0);
    check("clr.sticky",      32'(o_stk[1]), 32'd0);
    check("clr.err_count",   32'(o_ec[0]),  32'd0);
    go(0);
    check("prime.trans_count", 32'(o_tc[1]), 32'd0);
    go(1);
    check("resume.trans_count", 32'(o_tc[1]), 32'd1);

    // Saturation of the 4-bit counters under 20 consecutive errors.
    for (int k = 0; k < 20; k++) drive(0, 0);
    check("sat.err_count",   32'(o_ec[2]), 32'd15);
    check("sat.trans_count", 32'(o_tc[2]), 32'd15);
    check("sat.halt_count",  32'(o_ec[1]), 32'd1);

    // Full edge walk after a clear.
    drive(0, 0, 1'b1, 1'b1);
    go(0);
    for (int k = 1; k < WALK_LEN; k++) go(walk[k]);
    check("cov.cov_done",  32'(o_done[0]), 32'd1);
    check("cov.edge_cov",  32'(o_ecv[0]),  32'h3FFFF);
    check("cov.err_count", 32'(o_ec[0]),   32'd0);

    random_cycles(400);

    // Asynchronous reset in the middle of a cycle.
    @(negedge clk);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    compare_all();
    check("rst.err_count", 32'(o_ec[0]), 32'd0);
    tick();
    tick();
    @(negedge clk);
    rst = 1'b0;
    random_cycles(150);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
